// File: rtl/keypad_scan_ctrl.sv
// Column-strobed 4x4 keypad scanner: freezes on a press, debounces, emits one
// key_valid pulse per press, and waits for a stable release before rescanning.
//
// state           | meaning
// ----------------+-----------------------------------------------------------
// ST_SCAN         | strobe col_idx for SCAN_DIV cycles, sample rows at dwell end
// ST_DEBOUNCE     | scan frozen, rows must match pat for DEBOUNCE_CYC cycles
// ST_CAPTURE      | single cycle, key_code holds new key and key_valid is high
// ST_WAIT_RELEASE | rows must read zero for RELEASE_CYC cycles before rescanning
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 27000,
    parameter int unsigned DEBOUNCE_CYC = 15000,
    parameter int unsigned RELEASE_CYC  = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       busy
);

    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] REL_LAST  = 32'(RELEASE_CYC - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_CAPTURE,
        ST_WAIT_RELEASE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] count, count_nxt;
    logic [1:0]  col_idx, col_idx_nxt;
    logic [3:0]  pat, pat_nxt;
    logic [3:0]  key_code_nxt;
    logic [3:0]  row_m, row_s;
    logic [1:0]  row_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m <= 4'd0;
            row_s <= 4'd0;
        end else begin
            row_m <= row_in;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_SCAN;
            count    <= 32'd0;
            col_idx  <= 2'd0;
            pat      <= 4'd0;
            key_code <= 4'd0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            col_idx  <= col_idx_nxt;
            pat      <= pat_nxt;
            key_code <= key_code_nxt;
        end
    end

    // Several rows held at once resolve to the lowest row index.
    always_comb begin
        row_idx = 2'd0;
        if (pat[0])      row_idx = 2'd0;
        else if (pat[1]) row_idx = 2'd1;
        else if (pat[2]) row_idx = 2'd2;
        else if (pat[3]) row_idx = 2'd3;
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count + 32'd1;
        col_idx_nxt  = col_idx;
        pat_nxt      = pat;
        key_code_nxt = key_code;
        case (state)
            ST_SCAN: begin
                if (count == SCAN_LAST) begin
                    count_nxt = 32'd0;
                    if (row_s != 4'd0) begin
                        pat_nxt   = row_s;
                        state_nxt = ST_DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (row_s != pat) begin
                    state_nxt = ST_SCAN;
                    count_nxt = 32'd0;
                end else if (count == DEB_LAST) begin
                    // Load on entry to CAPTURE so key_code changes with key_valid.
                    state_nxt    = ST_CAPTURE;
                    count_nxt    = 32'd0;
                    key_code_nxt = {row_idx, col_idx};
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_WAIT_RELEASE;
                count_nxt = 32'd0;
            end
            ST_WAIT_RELEASE: begin
                if (row_s != 4'd0) begin
                    count_nxt = 32'd0;
                end else if (count == REL_LAST) begin
                    state_nxt   = ST_SCAN;
                    count_nxt   = 32'd0;
                    col_idx_nxt = col_idx + 2'd1;
                end
            end
            default: begin
                state_nxt = ST_SCAN;
                count_nxt = 32'd0;
            end
        endcase
    end

    assign col_out   = 4'b0001 << col_idx;
    assign busy      = (state != ST_SCAN);
    assign key_valid = (state == ST_CAPTURE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus random row activity,
// compared each cycle against an event-level keypad reference model.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int RC = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       busy;

    int n_vec;
    int n_err;
    int n_pulse;

    // Reference model: scan position, freeze phases and run-length counters.
    int         m_col, m_age, m_stable, m_zero;
    bit         m_frozen, m_deb, m_pulse, m_rel;
    logic [3:0] m_pat, m_code;
    logic [3:0] hist [2];

    keypad_scan_ctrl #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CYC(DC),
        .RELEASE_CYC (RC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] lowest_row(input logic [3:0] p);
        lowest_row = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (p[i]) lowest_row = 2'(i);
    endfunction

    task automatic model_reset();
        m_col = 0; m_age = 0; m_stable = 0; m_zero = 0;
        m_frozen = 0; m_deb = 0; m_pulse = 0; m_rel = 0;
        m_pat = 4'd0; m_code = 4'd0;
        hist[0] = 4'd0; hist[1] = 4'd0;
    endtask

    task automatic model_step();
        logic [3:0] rs;
        rs = hist[1];
        hist[1] = hist[0];
        hist[0] = row_in;
        if (m_pulse) begin
            m_pulse = 0;
            m_rel   = 1;
            m_zero  = 0;
        end else if (!m_frozen) begin
            m_age++;
            if (m_age == SD) begin
                m_age = 0;
                if (rs != 4'd0) begin
                    m_frozen = 1; m_deb = 1; m_pat = rs; m_stable = 0;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
        end else if (m_deb) begin
            if (rs != m_pat) begin
                m_frozen = 0; m_deb = 0; m_age = 0;
            end else begin
                m_stable++;
                if (m_stable == DC) begin
                    m_deb   = 0;
                    m_pulse = 1;
                    m_code  = {lowest_row(m_pat), 2'(m_col)};
                end
            end
        end else if (m_rel) begin
            if (rs != 4'd0) begin
                m_zero = 0;
            end else begin
                m_zero++;
                if (m_zero == RC) begin
                    m_rel = 0; m_frozen = 0; m_age = 0;
                    m_col = (m_col + 1) % 4;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (key_valid) n_pulse++;
        check("col_out",   col_out,          4'(1 << m_col));
        check("busy",      {3'b0, busy},      {3'b0, m_frozen});
        check("key_valid", {3'b0, key_valid}, {3'b0, m_pulse});
        check("key_code",  key_code,         m_code);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_col_out",   col_out,          4'b0001);
        check("rst_busy",      {3'b0, busy},      4'd0);
        check("rst_key_code",  key_code,         4'd0);
        check("rst_key_valid", {3'b0, key_valid}, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Returns just after the scan enters column c.
    task automatic wait_col(input int c);
        for (int i = 0; i < 64 && !(m_col == c && !m_frozen && m_age == 0); i++) tick();
        check("wait_col", col_out, 4'(1 << c));
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 64 && !busy; i++) tick();
        check("wait_busy", {3'b0, busy}, 4'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && busy; i++) tick();
        check("wait_idle", {3'b0, busy}, 4'd0);
    endtask

    initial begin
        int p0;
        n_vec = 0; n_err = 0; n_pulse = 0;
        reset  = 1'b1;
        row_in = 4'd0;
        model_reset();
        do_reset();

        // idle scan
        run(40);

        // clean press on column 1, row 2
        wait_col(1);
        row_in = 4'b0100;
        wait_busy();
        check("clean_col_frozen", col_out, 4'b0010);
        p0 = n_pulse;
        run(3);
        check("clean_key_valid", {3'b0, key_valid}, 4'd1);
        check("clean_key_code", key_code, 4'h9);
        run(4);
        check("clean_col_held", col_out, 4'b0010);
        row_in = 4'd0;
        run(10);
        check("clean_one_pulse", 4'(n_pulse - p0), 4'd1);

        // bounce: release at the moment the freeze is seen
        wait_col(2);
        row_in = 4'b0100;
        wait_busy();
        row_in = 4'd0;
        p0 = n_pulse;
        run(10);
        check("bounce_no_pulse", 4'(n_pulse - p0), 4'd0);
        check("bounce_code_kept", key_code, 4'h9);

        // release hold-off with chatter after capture
        wait_col(1);
        row_in = 4'b0100;
        wait_busy();
        run(4);
        for (int k = 0; k < 3; k++) begin
            row_in = 4'b0100; run(2);
            row_in = 4'b0000; run(2);
        end
        wait_idle();
        check("holdoff_next_col", col_out, 4'b0100);

        // multi-row on column 3, then reset while waiting for release
        wait_col(3);
        row_in = 4'b1010;
        wait_busy();
        run(3);
        check("multi_key_valid", {3'b0, key_valid}, 4'd1);
        check("multi_key_code", key_code, 4'h7);
        run(3);
        check("multi_busy_held", {3'b0, busy}, 4'd1);
        do_reset();
        row_in = 4'd0;
        p0 = n_pulse;
        run(20);
        check("post_reset_no_pulse", 4'(n_pulse - p0), 4'd0);

        // random row activity with occasional resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            case ($urandom_range(0, 3))
                0, 1:    row_in = 4'd0;
                2:       row_in = 4'(1 << $urandom_range(0, 3));
                default: row_in = 4'($urandom_range(0, 15));
            endcase
            run($urandom_range(1, 12));
        end
        row_in = 4'd0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
